// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the round-robin multiplier scheduler.
// State encoding plus the per-step partial-product control table.
package mult_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLR,
    ST_PP0,
    ST_PP1,
    ST_PP2,
    ST_PP3,
    ST_CAP,
    ST_RESP
  } sched_state_t;

  localparam logic [1:0] ANS_SHIFT0 = 2'd0;
  localparam logic [1:0] ANS_SHIFT2 = 2'd1;
  localparam logic [1:0] ANS_SHIFT4 = 2'd2;

  typedef struct packed {
    logic       asel;
    logic       bsel;
    logic [1:0] ans_sel;
  } pp_ctrl_t;

  // Element 0 is PP0; shift of each partial product is 2*(asel+bsel) bits.
  localparam pp_ctrl_t [3:0] PP_CTRL = {
    {1'b1, 1'b1, ANS_SHIFT4},
    {1'b1, 1'b0, ANS_SHIFT2},
    {1'b0, 1'b1, ANS_SHIFT2},
    {1'b0, 1'b0, ANS_SHIFT0}
  };

  function automatic logic [1:0] pp_step(input sched_state_t st);
    return 2'(st - ST_PP0);
  endfunction

endpackage

// File: rtl/mult_share_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester after rr_ptr,
// wrapping modulo NREQ, as a one-hot vector plus its index.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx,
  output logic            grant_vld
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!grant_vld && req[idx]) begin
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
        grant_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// Round-robin scheduler sharing one 2x2-partial-product 4x4 multiplier among NREQ requesters.
// Optional build macro MULT_SCHED_ZERO_BYPASS_EN: zero operands skip the datapath and answer at once.
//
// state | meaning
// IDLE  | waiting for a request; grant and latch operands
// CLR   | clear datapath accumulator
// PP0-3 | accumulate one shifted 2x2 partial product each
// CAP   | capture datapath result and owner id
// RESP  | present response until resp_ready
module mult_share_sched
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [7:0]        resp_data,
  output logic [IDW-1:0]    resp_id,
  output logic              busy,
  output logic [3:0]        dp_a,
  output logic [3:0]        dp_b,
  output logic              dp_asel,
  output logic              dp_bsel,
  output logic [1:0]        dp_ans_sel,
  output logic              dp_result_rst,
  input  logic [7:0]        dp_out
);

  sched_state_t    state, state_nxt;
  logic [IDW-1:0]  rr_ptr;
  logic [3:0]      op_a, op_b;
  logic [IDW-1:0]  id_r;
  logic [7:0]      resp_data_r;
  logic [IDW-1:0]  resp_id_r;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_idx;
  logic            grant_vld;
  logic            accept;
  logic [3:0]      gnt_a, gnt_b;
  pp_ctrl_t        ctrl;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign gnt_a = req_a[4*grant_idx +: 4];
  assign gnt_b = req_b[4*grant_idx +: 4];

  always_comb begin
    state_nxt     = state;
    req_ready     = '0;
    accept        = 1'b0;
    busy          = 1'b1;
    resp_valid    = 1'b0;
    dp_asel       = 1'b0;
    dp_bsel       = 1'b0;
    dp_ans_sel    = ANS_SHIFT0;
    dp_result_rst = 1'b0;
    ctrl          = PP_CTRL[0];
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (grant_vld) begin
          req_ready = grant;
          accept    = 1'b1;
          state_nxt = ST_CLR;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
          if (gnt_a == 4'd0 || gnt_b == 4'd0) state_nxt = ST_RESP;
`endif
        end
      end
      ST_CLR: begin
        dp_result_rst = 1'b1;
        state_nxt     = ST_PP0;
      end
      ST_PP0, ST_PP1, ST_PP2, ST_PP3: begin
        ctrl       = PP_CTRL[pp_step(state)];
        dp_asel    = ctrl.asel;
        dp_bsel    = ctrl.bsel;
        dp_ans_sel = ctrl.ans_sel;
        state_nxt  = (state == ST_PP3) ? ST_CAP : sched_state_t'(state + 3'd1);
      end
      ST_CAP:  state_nxt = ST_RESP;
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= IDW'(NREQ - 1);
      op_a        <= '0;
      op_b        <= '0;
      id_r        <= '0;
      resp_data_r <= '0;
      resp_id_r   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a   <= gnt_a;
        op_b   <= gnt_b;
        id_r   <= grant_idx;
        rr_ptr <= grant_idx;
        // Bypassed grants jump straight to RESP, so the answer is loaded here.
        if (state_nxt == ST_RESP) begin
          resp_data_r <= '0;
          resp_id_r   <= grant_idx;
        end
      end
      if (state == ST_CAP) begin
        resp_data_r <= dp_out;
        resp_id_r   <= id_r;
      end
    end
  end

  assign dp_a      = op_a;
  assign dp_b      = op_b;
  assign resp_data = resp_data_r;
  assign resp_id   = resp_id_r;

endmodule

// File: tb/tb_mult_share_sched.sv
// Self-checking bench for mult_share_sched: behavioural accumulator datapath, transaction-level
// reference model compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_mult_share_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 3;
`ifdef MULT_SCHED_ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [4*NREQ-1:0] req_a = '0;
  logic [4*NREQ-1:0] req_b = '0;
  logic [NREQ-1:0]   req_ready;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [7:0]        resp_data;
  logic [IDW-1:0]    resp_id;
  logic              busy;
  logic [3:0]        dp_a, dp_b;
  logic              dp_asel, dp_bsel;
  logic [1:0]        dp_ans_sel;
  logic              dp_result_rst;
  logic [7:0]        dp_out;

  mult_share_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .busy(busy), .dp_a(dp_a), .dp_b(dp_b),
    .dp_asel(dp_asel), .dp_bsel(dp_bsel), .dp_ans_sel(dp_ans_sel),
    .dp_result_rst(dp_result_rst), .dp_out(dp_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: phase 0 = idle, 1..6 = the six cycles after an accept, 7 = response pending.
  bit m_on = 1'b0;
  int m_phase = 0, m_last = NREQ - 1, m_id = 0, m_a = 0, m_b = 0;
  int m_g, m_ga, m_gb;

  function automatic int pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  always_comb begin
    m_g  = pick(req_valid, m_last);
    m_ga = int'(req_a[4*(m_g < 0 ? 0 : m_g) +: 4]);
    m_gb = int'(req_b[4*(m_g < 0 ? 0 : m_g) +: 4]);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_on    <= 1'b1;
      m_phase <= 0;
      m_last  <= NREQ - 1;
    end else if (m_on) begin
      if (m_phase == 0) begin
        if (m_g >= 0) begin
          m_last  <= m_g;
          m_id    <= m_g;
          m_a     <= m_ga;
          m_b     <= m_gb;
          m_phase <= (BYP && (m_ga == 0 || m_gb == 0)) ? 7 : 1;
        end
      end else if (m_phase == 7) begin
        if (resp_ready) m_phase <= 0;
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  // Behavioural datapath: sum of shifted 2x2 partial products, enabled during the four PP cycles.
  logic [7:0] acc = '0;
  int pp;
  assign dp_out = acc;
  always_comb pp = (int'(dp_asel ? dp_a[3:2] : dp_a[1:0]) * int'(dp_bsel ? dp_b[3:2] : dp_b[1:0]))
                   << (2 * int'(dp_ans_sel));
  always @(posedge clk) begin
    if (rst || dp_result_rst) acc <= '0;
    else if (m_phase >= 2 && m_phase <= 5) acc <= acc + 8'(pp);
  end

  task automatic compare_cycle();
    int k, exp_ctrl;
    chk("req_ready", int'(req_ready), (m_phase == 0 && m_g >= 0) ? (1 << m_g) : 0);
    chk("busy", int'(busy), int'(m_phase != 0));
    chk("resp_valid", int'(resp_valid), int'(m_phase == 7));
    chk("dp_result_rst", int'(dp_result_rst), int'(m_phase == 1));
    k = m_phase - 2;
    exp_ctrl = (k >= 0 && k <= 3) ? ((k / 2) * 8 + (k % 2) * 4 + (k / 2 + k % 2)) : 0;
    chk("dp_ctrl", int'({dp_asel, dp_bsel, dp_ans_sel}), exp_ctrl);
    if (m_phase >= 1 && m_phase <= 6) begin
      chk("dp_a", int'(dp_a), m_a);
      chk("dp_b", int'(dp_b), m_b);
    end
    if (m_phase == 7) begin
      chk("resp_data", int'(resp_data), m_a * m_b);
      chk("resp_id", int'(resp_id), m_id);
    end
  endtask

  always @(negedge clk) if (m_on) compare_cycle();

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; resp_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One request on requester i; literal checks of accept, latency, product, hold and release.
  task automatic run_one(input int i, input int a, input int b, input int lat, input int hold,
                         input bit trace);
    int t0, w;
    int exp_tr[6];
    exp_tr = '{16, 0, 5, 9, 14, 0};
    @(posedge clk); #1;
    req_valid[i] = 1'b1;
    req_a[4*i +: 4] = 4'(a);
    req_b[4*i +: 4] = 4'(b);
    resp_ready = (hold == 0);
    w = 0;
    do begin @(negedge clk); w++; end while (!req_ready[i] && w < 40);
    t0 = cyc;
    chk("accept_seen", int'(req_ready[i]), 1);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    if (trace)
      for (int j = 0; j < 6; j++) begin
        @(negedge clk);
        chk("ctrl_trace", int'({dp_result_rst, dp_asel, dp_bsel, dp_ans_sel}), exp_tr[j]);
      end
    w = 0;
    do begin @(negedge clk); w++; end while (!resp_valid && w < 40);
    chk("latency", cyc - t0, lat);
    chk("lit_data", int'(resp_data), a * b);
    chk("lit_id", int'(resp_id), i);
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", int'(resp_valid), 1);
      chk("hold_data", int'(resp_data), a * b);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      resp_ready = 1'b1;
      @(negedge clk);
      chk("hold_valid", int'(resp_valid), 1);
    end
    @(negedge clk);
    chk("resp_drop", int'(resp_valid), 0);
  endtask

  // Requesters 0 and 2 both hold valid for two operations each; rr order must alternate.
  task automatic rr_pair();
    int ids[$], dat[$];
    int n0, n2, w;
    logic [NREQ-1:0] accd;
    int exp_ids[4], exp_dat[4];
    exp_ids = '{0, 2, 0, 2};
    exp_dat = '{28, 20, 28, 20};
    n0 = 0; n2 = 0; w = 0;
    do_reset();
    req_a[3:0] = 4'd7;  req_b[3:0] = 4'd4;
    req_a[11:8] = 4'd4; req_b[11:8] = 4'd5;
    req_valid[0] = 1'b1; req_valid[2] = 1'b1; resp_ready = 1'b1;
    while (ids.size() < 4 && w < 80) begin
      @(negedge clk);
      w++;
      accd = req_ready;
      if (resp_valid) begin ids.push_back(int'(resp_id)); dat.push_back(int'(resp_data)); end
      @(posedge clk); #1;
      if (accd[0]) begin n0++; if (n0 == 2) req_valid[0] = 1'b0; end
      if (accd[2]) begin n2++; if (n2 == 2) req_valid[2] = 1'b0; end
    end
    chk("rr_count", ids.size(), 4);
    for (int j = 0; j < 4 && j < ids.size(); j++) begin
      chk("rr_id", ids[j], exp_ids[j]);
      chk("rr_data", dat[j], exp_dat[j]);
    end
  endtask

  task automatic reset_mid_op();
    int w;
    do_reset();
    @(posedge clk); #1;
    req_valid[1] = 1'b1; req_a[7:4] = 4'd8; req_b[7:4] = 4'd3; resp_ready = 1'b1;
    w = 0;
    do begin @(negedge clk); w++; end while (!req_ready[1] && w < 40);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("pp2_ctrl", int'({dp_asel, dp_bsel, dp_ans_sel}), 9);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", int'(busy), 0);
    chk("abort_dp", int'({dp_a, dp_b, dp_asel, dp_bsel, dp_ans_sel, dp_result_rst}), 0);
    chk("abort_resp", int'(resp_valid), 0);
    run_one(1, 15, 15, 7, 0, 1'b0);
  endtask

  task automatic random_phase(input int ncyc);
    logic [NREQ-1:0] accd;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      accd = req_ready;
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (accd[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            req_valid[i] = 1'b1;
            req_a[4*i +: 4] = 4'($urandom_range(0, 15));
            req_b[4*i +: 4] = 4'($urandom_range(0, 15));
          end
        end else if ($urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 399) == 0);
    end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = '0; resp_ready = 1'b1;
    repeat (20) @(posedge clk);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_outputs", int'({req_ready, resp_data, resp_id, dp_a, dp_b, dp_asel, dp_bsel,
                             dp_ans_sel, dp_result_rst}), 0);
    run_one(0, 12, 9, 7, 0, 1'b1);
    rr_pair();
    do_reset();
    run_one(0, 10, 12, 7, 5, 1'b0);
    reset_mid_op();
    do_reset();
    run_one(3, 0, 13, BYP ? 1 : 7, 0, 1'b0);
    run_one(2, 13, 11, 7, 2, 1'b1);
    random_phase(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
